sm_mac_unit: RTL and testbench

//  Sequential multiply-accumulate for one neuron over a stream of sign-magnitude fixed-point (input, weight) pairs.

---
 rtl/sm_fixed_pkg.sv | 55 +++++
 rtl/sm_seq_mult.sv | 72 +++++++
 rtl/sm_mac_unit.sv | 131 +++++++++++++
 tb/tb_sm_mac_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sm_fixed_pkg.sv
// Shared encodings and sign-magnitude <-> two's-complement helpers for the MAC datapath.
package sm_fixed_pkg;

  // FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Helpers work on a 64-bit container; callers pass the real word width N and
  // size their accumulator (ACC_W) to fit inside it.
  localparam int unsigned SM_MAX_W = 64;

  typedef struct packed {
    logic                sat;
    logic [SM_MAX_W-1:0] word;  // sign in bit n-1, magnitude below
  } sm_fmt_t;

  // Signed magnitude to two's complement; negative zero yields plain zero.
  function automatic logic signed [SM_MAX_W-1:0] sm_to_tc(input logic              sgn,
                                                          input logic [SM_MAX_W-1:0] mag);
    logic signed [SM_MAX_W-1:0] v;
    v = $signed(mag);
    return sgn ? -v : v;
  endfunction

  // Two's complement to n-bit sign-magnitude with symmetric saturation at
  // +/-(2^(n-1)-1). relu forces every negative outcome (clipped or not) to +0.
  function automatic sm_fmt_t tc_to_sm_sat(input logic signed [SM_MAX_W-1:0] acc,
                                           input int unsigned                n,
                                           input logic                       relu);
    logic        [SM_MAX_W-1:0] sbit;
    logic signed [SM_MAX_W-1:0] maxm;
    sm_fmt_t                    r;
    sbit   = 64'd1 << (n - 1);
    maxm   = $signed(sbit - 64'd1);
    r.sat  = 1'b0;
    r.word = '0;
    if (acc > maxm) begin
      r.sat  = 1'b1;
      r.word = $unsigned(maxm);
    end else if (acc < -maxm) begin
      if (!relu) begin
        r.sat  = 1'b1;
        r.word = sbit | $unsigned(maxm);
      end
    end else if (acc < 64'sd0) begin
      if (!relu) r.word = sbit | $unsigned(-acc);
    end else begin
      r.word = $unsigned(acc);
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_seq_mult.sv
// Radix-2 shift-add unsigned multiplier: N-1 iterations, one partial product per cycle.
module sm_seq_mult #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-2:0]   mag_a,
  input  logic [N-2:0]   mag_w,
  output logic           busy,
  output logic           done,
  output logic [2*N-3:0] prod
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned PW = 2 * N - 2;
  localparam int unsigned CW = $clog2(MW + 1);

  logic [PW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] mplier_q, mplier_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          last_iter;

  // done marks the final iteration; prod is complete right after this edge,
  // which is when the top FSM sits in ACC.
  assign last_iter = busy_q && (cnt_q == CW'(MW - 1));
  assign done      = last_iter;
  assign busy      = busy_q;
  assign prod      = prod_q;

  // Next-state: load operands on start, else one conditional add and shift per cycle
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{(PW - MW){1'b0}}, mag_a};
      mplier_d = mag_w;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_iter) busy_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/sm_mac_unit.sv
// Sign-magnitude multiply-accumulate for one neuron with saturating, optionally ReLU'd output.
module sm_mac_unit
  import sm_fixed_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned GUARD = 4,
  parameter int unsigned ACT   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_w,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat
);

  localparam int unsigned ACC_W = N + GUARD;
  localparam int unsigned MW    = N - 1;
  localparam int unsigned PW    = 2 * N - 2;

  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sgn_q, sgn_d;
  logic                    last_q, last_d;
  logic [N-1:0]            out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic                    mult_start, mult_busy, mult_done;
  logic [PW-1:0]           mult_prod;
  logic [MW-1:0]           pm;
  logic signed [63:0]      term;
  logic signed [ACC_W-1:0] acc_sum;
  sm_fmt_t                 fmt;
  logic                    unused_bits;

  sm_seq_mult #(
    .N(N)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .start(mult_start),
    .mag_a(in_a[N-2:0]),
    .mag_w(in_w[N-2:0]),
    .busy (mult_busy),
    .done (mult_done),
    .prod (mult_prod)
  );

  // Drop the N-1 fraction LSBs of the Q0.2(N-1) product to get back to Q0.(N-1)
  assign pm = mult_prod[PW-1:MW];

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign unused_bits = ^{term[63:ACC_W], fmt.word[63:N], mult_prod[MW-1:0], mult_busy};

  // Signed term, running sum and its formatted view, computed every cycle
  always_comb begin
    term    = sm_to_tc(sgn_q, {{(64 - MW){1'b0}}, pm});
    acc_sum = acc_q + term[ACC_W-1:0];
    fmt     = tc_to_sm_sat({{(64 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum}, N, ACT != 0);
  end

  // FSM and datapath next-state
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sgn_d      = sgn_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    mult_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sgn_d      = in_a[N-1] ^ in_w[N-1];
          last_d     = in_last;
          mult_start = 1'b1;
          state_d    = S_MUL;
        end
      end
      S_MUL: begin
        if (mult_done) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = acc_sum;
        if (last_q) begin
          out_data_d = fmt.word[N-1:0];
          out_sat_d  = fmt.sat;
          state_d    = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation and discards the partial sum
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      sgn_q      <= 1'b0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sgn_q      <= sgn_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_sm_mac_unit.sv
// Scoreboard bench for sm_mac_unit: identity and ReLU instances driven in lockstep.
module tb_sm_mac_unit;

  localparam int unsigned N  = 8;
  localparam int          NV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_w = '0;

  logic       in_ready, out_valid, out_sat;
  logic [7:0] out_data;
  logic       r_in_ready, r_out_valid, r_out_sat;
  logic [7:0] r_out_data;

  sm_mac_unit #(.N(N), .GUARD(4), .ACT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_w(in_w), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  sm_mac_unit #(.N(N), .GUARD(4), .ACT(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .in_a(in_a),
    .in_w(in_w), .in_last(in_last), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_data(r_out_data), .out_sat(r_out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic [7:0] rd;
    logic       rs;
  } exp_t;

  exp_t sb_q[$];

  // Vector table: pair 0 uses (va0, vw0); every later pair uses (va1, vw1)
  int         vn [NV];
  logic [7:0] va0[NV];
  logic [7:0] vw0[NV];
  logic [7:0] va1[NV];
  logic [7:0] vw1[NV];
  exp_t       vexp[NV];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_vec(input int i, input int n, input logic [7:0] a0, input logic [7:0] w0,
                         input logic [7:0] a1, input logic [7:0] w1, input exp_t e);
    vn[i] = n; va0[i] = a0; vw0[i] = w0; va1[i] = a1; vw1[i] = w1; vexp[i] = e;
  endtask

  // Wait for in_ready, present one pair; returns the handshake cycle
  task automatic send_pair(input logic [7:0] a, input logic [7:0] w, input logic last,
                           output int t_hs);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_w     = w;
    in_last  = last;
    t_hs     = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the unit to come back, check latency, optionally stall, then drain a result
  task automatic wait_done(input int t_hs, input logic last, input logic stall);
    int         n = 0;
    exp_t       e;
    logic [7:0] d0;
    logic       s0;
    while (!(out_valid || in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", cyc - t_hs, N + 1);
    if (!last) begin
      check_eq("mid_in_ready", in_ready, 1);
      check_eq("mid_out_valid", out_valid, 0);
      return;
    end
    check_eq("out_valid", out_valid, 1);
    check_eq("relu_out_valid", r_out_valid, 1);
    if (stall) begin
      d0 = out_data;
      s0 = out_sat;
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        in_a     = 8'h7F;
        in_w     = 8'h7F;
        in_last  = 1'b1;
        @(negedge clk);
        check_eq("stall_data", out_data, d0);
        check_eq("stall_sat", out_sat, s0);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_eq("out_data", out_data, e.d);
      check_eq("out_sat", out_sat, e.s);
      check_eq("relu_out_data", r_out_data, e.rd);
      check_eq("relu_out_sat", r_out_sat, e.rs);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_out_valid", out_valid, 0);
    check_eq("post_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input int i, input logic stall);
    int   t;
    logic last;
    for (int p = 0; p < vn[i]; p++) begin
      last = (p == vn[i] - 1);
      if (last) sb_q.push_back(vexp[i]);
      send_pair((p == 0) ? va0[i] : va1[i], (p == 0) ? vw0[i] : vw1[i], last, t);
      wait_done(t, last, stall);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int t;
    //          idx n  a0     w0     a1     w1      d      s     rd     rs
    set_vec(0, 1, 8'h40, 8'h40, 8'h00, 8'h00, '{8'h20, 1'b0, 8'h20, 1'b0});
    set_vec(1, 1, 8'h40, 8'hC0, 8'h00, 8'h00, '{8'hA0, 1'b0, 8'h00, 1'b0});
    set_vec(2, 1, 8'h01, 8'h01, 8'h00, 8'h00, '{8'h00, 1'b0, 8'h00, 1'b0});
    set_vec(3, 4, 8'h7F, 8'h7F, 8'h7F, 8'h7F, '{8'h7F, 1'b1, 8'h7F, 1'b1});
    set_vec(4, 4, 8'h7F, 8'hFF, 8'h7F, 8'hFF, '{8'hFF, 1'b1, 8'h00, 1'b0});
    set_vec(5, 2, 8'h40, 8'h40, 8'hC0, 8'h40, '{8'h00, 1'b0, 8'h00, 1'b0});
    set_vec(6, 2, 8'h80, 8'h40, 8'h20, 8'h40, '{8'h10, 1'b0, 8'h10, 1'b0});
    set_vec(7, 2, 8'h7F, 8'h7F, 8'h7F, 8'h02, '{8'h7F, 1'b0, 8'h7F, 1'b0});
    set_vec(8, 2, 8'hFF, 8'h7F, 8'h7F, 8'h82, '{8'hFF, 1'b0, 8'h00, 1'b0});
    set_vec(9, 1, 8'h40, 8'h40, 8'h00, 8'h00, '{8'h20, 1'b0, 8'h20, 1'b0});

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(i, 1'b0);

    // Consumer back-pressure in DONE
    run_vec(9, 1'b1);

    // Reset in the middle of the second pair's multiply
    send_pair(8'h40, 8'h40, 1'b0, t);
    wait_done(t, 1'b0, 1'b0);
    send_pair(8'h40, 8'h40, 1'b0, t);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_out_data", out_data, 0);
    check_eq("abort_out_sat", out_sat, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_after", in_ready, 1);
    run_vec(0, 1'b0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
